// File: rtl/capture_square_grid_pkg.sv
// Shared constants, state encoding and grid/square address helpers for the
// grid-square capture path.
package capture_square_grid_pkg;

    localparam int unsigned SQUARE_SIZE  = 20;
    localparam int unsigned SQUARE_WORDS = SQUARE_SIZE * SQUARE_SIZE;
    localparam int unsigned SCREEN_W     = 160;
    localparam int unsigned SCREEN_H     = 120;
    localparam int unsigned GRID_COLS    = 8;
    localparam int unsigned GRID_ROWS    = 6;
    localparam int unsigned COLOUR_W     = 9;
    localparam int unsigned ADDR_W       = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // 20x20 memory address translator: row-major word index of (cx, cy).
    function automatic logic [ADDR_W-1:0] square_addr(input logic [4:0] cx,
                                                      input logic [4:0] cy);
        return ADDR_W'(cy) * ADDR_W'(SQUARE_SIZE) + ADDR_W'(cx);
    endfunction

    function automatic logic [7:0] cell_x(input logic [3:0] gx,
                                          input logic [4:0] cx);
        return 8'(gx) * 8'(SQUARE_SIZE) + 8'(cx);
    endfunction

    function automatic logic [6:0] cell_y(input logic [3:0] gy,
                                          input logic [4:0] cy);
        return 7'(gy) * 7'(SQUARE_SIZE) + 7'(cy);
    endfunction

endpackage

// File: rtl/capture_square_grid_tag_pipe.sv
// Fixed-depth valid+address shift register that tracks frame-buffer reads
// in flight so each returning word knows its square RAM address.
module latency_tag_pipe #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              any_valid
);

    logic [DEPTH-1:0]             valid;
    logic [DEPTH-1:0][ADDR_W-1:0] addr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (clear) begin
                    valid <= '0;
                    addr  <= '0;
                end else begin
                    valid[0] <= in_valid;
                    addr[0]  <= in_addr;
                end
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (clear) begin
                    valid <= '0;
                    addr  <= '0;
                end else begin
                    valid <= {valid[DEPTH-2:0], in_valid};
                    addr  <= {addr[DEPTH-2:0], in_addr};
                end
            end
        end
    endgenerate

    assign out_valid = valid[DEPTH-1];
    assign out_addr  = addr[DEPTH-1];
    assign any_valid = |valid;

endmodule

// File: rtl/capture_square_grid.sv
// Copies one 20x20 cell of the frame-buffer shadow RAM into the square RAM,
// row-major, under a start/done handshake from the game controller.
module capture_square_grid
    import capture_square_grid_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [3:0]          GRID_X,
    input  logic [3:0]          GRID_Y,
    output logic [7:0]          fb_x,
    output logic [6:0]          fb_y,
    output logic                fb_rd,
    input  logic [COLOUR_W-1:0] fb_q,
    output logic [ADDR_W-1:0]   wr_address,
    output logic [COLOUR_W-1:0] wr_data,
    output logic                wren,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam logic [4:0] LAST = 5'(SQUARE_SIZE - 1);

    state_t      state;
    logic [3:0]  gx;
    logic [3:0]  gy;
    logic [4:0]  cx;
    logic [4:0]  cy;
    logic        tag_valid;
    logic [ADDR_W-1:0] tag_addr;
    logic        tags_pending;

    // cx/cy always name the read currently presented on fb_x/fb_y, so the
    // tag entering the pipe lines up with fb_rd in the same cycle.
    latency_tag_pipe #(
        .DEPTH  (READ_LATENCY),
        .ADDR_W (ADDR_W)
    ) u_tag_pipe (
        .clk       (clk),
        .clear     (!resetn),
        .in_valid  (fb_rd),
        .in_addr   (square_addr(cx, cy)),
        .out_valid (tag_valid),
        .out_addr  (tag_addr),
        .any_valid (tags_pending)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            gx    <= '0;
            gy    <= '0;
            cx    <= '0;
            cy    <= '0;
            fb_x  <= '0;
            fb_y  <= '0;
            fb_rd <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gx <= GRID_X;
                        gy <= GRID_Y;
                        cx <= '0;
                        cy <= '0;
                        if (GRID_X >= 4'(GRID_COLS) || GRID_Y >= 4'(GRID_ROWS)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            // First read goes out in the cycle right after start.
                            state <= ISSUE;
                            busy  <= 1'b1;
                            error <= 1'b0;
                            fb_rd <= 1'b1;
                            fb_x  <= cell_x(GRID_X, 5'd0);
                            fb_y  <= cell_y(GRID_Y, 5'd0);
                        end
                    end
                end

                ISSUE: begin
                    if (cx == LAST && cy == LAST) begin
                        fb_rd <= 1'b0;
                        state <= DRAIN;
                    end else if (cx == LAST) begin
                        cx   <= '0;
                        cy   <= cy + 5'd1;
                        fb_x <= cell_x(gx, 5'd0);
                        fb_y <= cell_y(gy, cy + 5'd1);
                    end else begin
                        cx   <= cx + 5'd1;
                        fb_x <= cell_x(gx, cx + 5'd1);
                    end
                end

                DRAIN: begin
                    if (!tags_pending) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wren       <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
        end else begin
            wren <= tag_valid;
            if (tag_valid) begin
                wr_address <= tag_addr;
                wr_data    <= fb_q;
            end
        end
    end

endmodule

// File: tb/tb_capture_square_grid.sv
// Bench for capture_square_grid: two instances (read latency 2 and 1) share
// stimulus and are checked every cycle against a timeline model of a capture.
module tb_capture_square_grid;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [3:0] grid_x = '0;
    logic [3:0] grid_y = '0;

    logic [7:0] fb_x [2];
    logic [6:0] fb_y [2];
    logic       fb_rd [2];
    logic [8:0] fb_q [2];
    logic [8:0] wr_address [2];
    logic [8:0] wr_data [2];
    logic       wren [2];
    logic       busy [2];
    logic       done [2];
    logic       error [2];

    always #5 clk = ~clk;

    capture_square_grid #(.READ_LATENCY(LAT0)) dut0 (
        .clk(clk), .resetn(resetn), .start(start), .GRID_X(grid_x), .GRID_Y(grid_y),
        .fb_x(fb_x[0]), .fb_y(fb_y[0]), .fb_rd(fb_rd[0]), .fb_q(fb_q[0]),
        .wr_address(wr_address[0]), .wr_data(wr_data[0]), .wren(wren[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0])
    );

    capture_square_grid #(.READ_LATENCY(LAT1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start), .GRID_X(grid_x), .GRID_Y(grid_y),
        .fb_x(fb_x[1]), .fb_y(fb_y[1]), .fb_rd(fb_rd[1]), .fb_q(fb_q[1]),
        .wr_address(wr_address[1]), .wr_data(wr_data[1]), .wren(wren[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1])
    );

    int cyc = 0;
    bit checking = 0;
    int n_tests = 0;
    int n_fail = 0;

    // Model of each instance: the accepted transaction and sticky state.
    bit act [2];
    int t0 [2];
    int mgx [2];
    int mgy [2];
    bit merr [2];
    bit err_flag [2];
    int last_a [2];
    int last_d [2];

    // Frame-buffer delay lines.
    bit pv [2][3];
    int pq [2][3];

    // Per-test observations.
    int wr_cnt [2], first_wr [2], first_addr [2], last_wr [2], last_wa [2], last_wd [2];
    int done_cyc [2], err_at_done [2], rd_cnt [2];
    int min_x [2], max_x [2], min_y [2], max_y [2];
    int cap [2][400];

    function automatic int lat(int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int pix_q(int x, int y);
        return ((y % 8) << 6) | (x % 64);
    endfunction

    function automatic bit model_idle(int d, int c);
        if (!act[d]) return 1'b1;
        return c >= t0[d] + (merr[d] ? 2 : 403 + lat(d));
    endfunction

    task automatic check(string name, int d, int actual, int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d",
                     name, d, cyc, actual, expected);
        end
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] = 0; first_wr[d] = -1; first_addr[d] = -1; last_wr[d] = -1;
            last_wa[d] = -1; last_wd[d] = -1; done_cyc[d] = -1; err_at_done[d] = -1;
            rd_cnt[d] = 0; min_x[d] = 999; max_x[d] = -1; min_y[d] = 999; max_y[d] = -1;
        end
    endtask

    // Clock-edge process: frame-buffer model and transaction acceptance.
    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int i = 2; i > 0; i--) begin
                pv[d][i] = pv[d][i-1];
                pq[d][i] = pq[d][i-1];
            end
            pv[d][0] = fb_rd[d];
            pq[d][0] = pix_q(int'(fb_x[d]), int'(fb_y[d]));
            if (!resetn) begin
                act[d] = 0; err_flag[d] = 0; last_a[d] = 0; last_d[d] = 0;
            end else if (start && model_idle(d, cyc)) begin
                act[d] = 1; t0[d] = cyc; mgx[d] = int'(grid_x); mgy[d] = int'(grid_y);
                merr[d] = (grid_x >= 8) || (grid_y >= 6);
                err_flag[d] = merr[d];
            end
        end
        cyc++;
        checking = 1;
        #1;
        for (int d = 0; d < 2; d++)
            fb_q[d] = pv[d][lat(d)-1] ? 9'(pq[d][lat(d)-1]) : 9'($urandom);
    end

    // Compare process: every output of both instances, every cycle.
    initial forever begin
        @(negedge clk);
        if (checking) begin
            for (int d = 0; d < 2; d++) begin
                int dd, L, k, ex, ey, ea, edt;
                bit e_rd, e_busy, e_done, e_wr;
                L = lat(d);
                e_rd = 0; e_busy = 0; e_done = 0; e_wr = 0; ex = 0; ey = 0;
                ea = last_a[d]; edt = last_d[d];
                if (act[d]) begin
                    dd = cyc - t0[d];
                    if (merr[d]) begin
                        e_done = (dd == 1);
                    end else begin
                        e_rd = (dd >= 1 && dd <= 400);
                        if (e_rd) begin
                            k = dd - 1;
                            ex = mgx[d] * 20 + k % 20;
                            ey = mgy[d] * 20 + k / 20;
                        end
                        e_busy = (dd >= 1 && dd <= 401 + L);
                        e_done = (dd == 402 + L);
                        if (dd >= 2 + L && dd <= 401 + L) begin
                            e_wr = 1;
                            k = dd - 2 - L;
                            ea = k;
                            edt = pix_q(mgx[d] * 20 + k % 20, mgy[d] * 20 + k / 20);
                        end
                    end
                end
                check("fb_rd", d, int'(fb_rd[d]), int'(e_rd));
                check("busy", d, int'(busy[d]), int'(e_busy));
                check("done", d, int'(done[d]), int'(e_done));
                check("wren", d, int'(wren[d]), int'(e_wr));
                check("error", d, int'(error[d]), int'(err_flag[d]));
                check("wr_address", d, int'(wr_address[d]), ea);
                check("wr_data", d, int'(wr_data[d]), edt);
                if (e_rd) begin
                    check("fb_x", d, int'(fb_x[d]), ex);
                    check("fb_y", d, int'(fb_y[d]), ey);
                end
                last_a[d] = ea; last_d[d] = edt;

                if (wren[d]) begin
                    wr_cnt[d]++;
                    if (first_wr[d] < 0) begin
                        first_wr[d] = cyc; first_addr[d] = int'(wr_address[d]);
                    end
                    last_wr[d] = cyc; last_wa[d] = int'(wr_address[d]);
                    last_wd[d] = int'(wr_data[d]);
                    cap[d][wr_address[d] % 400] = int'(wr_data[d]);
                end
                if (fb_rd[d]) begin
                    rd_cnt[d]++;
                    if (int'(fb_x[d]) < min_x[d]) min_x[d] = int'(fb_x[d]);
                    if (int'(fb_x[d]) > max_x[d]) max_x[d] = int'(fb_x[d]);
                    if (int'(fb_y[d]) < min_y[d]) min_y[d] = int'(fb_y[d]);
                    if (int'(fb_y[d]) > max_y[d]) max_y[d] = int'(fb_y[d]);
                end
                if (done[d]) begin
                    done_cyc[d] = cyc; err_at_done[d] = int'(error[d]);
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(int x, int y, output int t);
        grid_x = 4'(x);
        grid_y = 4'(y);
        start = 1'b1;
        t = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(int d, int limit);
        int n;
        n = 0;
        while (done_cyc[d] < 0 && n < limit) begin
            tick(1);
            n++;
        end
        check("done_timeout", d, int'(n < limit), 1);
    endtask

    initial begin
        int t, r, gx, gy;
        for (int d = 0; d < 2; d++) begin
            fb_q[d] = '0;
            act[d] = 0; err_flag[d] = 0; last_a[d] = 0; last_d[d] = 0;
            for (int i = 0; i < 3; i++) begin pv[d][i] = 0; pq[d][i] = 0; end
        end
        clear_stats();
        resetn = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(2);

        // Basic capture at grid (2,1).
        clear_stats();
        do_start(2, 1, t);
        wait_done(0, 1000);
        check("basic_wr_count", 0, wr_cnt[0], 400);
        check("basic_first_wr", 0, first_wr[0] - t, 4);
        check("basic_last_wr", 0, last_wr[0] - t, 403);
        check("basic_done_cyc", 0, done_cyc[0] - t, 404);
        check("basic_err", 0, err_at_done[0], 0);
        check("word0", 0, cap[0][0], 296);
        check("word19", 0, cap[0][19], 315);
        check("word20", 0, cap[0][20], 360);
        check("word399", 0, cap[0][399], 507);
        check("lat1_first_wr", 1, first_wr[1] - t, 3);
        check("lat1_done_cyc", 1, done_cyc[1] - t, 403);
        check("lat1_word399", 1, cap[1][399], 507);
        tick(3);

        // Out-of-range grid coordinates.
        for (int v = 0; v < 2; v++) begin
            clear_stats();
            if (v == 0) do_start(8, 0, t); else do_start(0, 6, t);
            wait_done(0, 20);
            tick(3);
            for (int d = 0; d < 2; d++) begin
                check("oor_done_cyc", d, done_cyc[d] - t, 1);
                check("oor_err", d, err_at_done[d], 1);
                check("oor_reads", d, rd_cnt[d], 0);
                check("oor_writes", d, wr_cnt[d], 0);
            end
        end

        // Start while busy at grid (0,0), latency variant checked on dut1.
        clear_stats();
        do_start(0, 0, t);
        tick(49);
        grid_x = 4'd5;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(0, 1000);
        tick(2);
        for (int d = 0; d < 2; d++) begin
            check("busy_start_max_x", d, max_x[d], 19);
            check("busy_start_writes", d, wr_cnt[d], 400);
        end
        check("lat1_first_wr00", 1, first_wr[1] - t, 3);
        check("lat1_done00", 1, done_cyc[1] - t, 403);

        // Reset in cycle 100 of a capture, then a fresh capture.
        do_start(3, 2, t);
        tick(99);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        clear_stats();
        tick(10);
        for (int d = 0; d < 2; d++) begin
            check("post_reset_writes", d, wr_cnt[d], 0);
            check("post_reset_reads", d, rd_cnt[d], 0);
        end
        clear_stats();
        do_start(4, 3, t);
        wait_done(0, 1000);
        tick(2);
        for (int d = 0; d < 2; d++) begin
            check("fresh_first_addr", d, first_addr[d], 0);
            check("fresh_writes", d, wr_cnt[d], 400);
        end

        // Back-to-back: start again in the first idle cycle after done.
        clear_stats();
        do_start(1, 1, t);
        wait_done(0, 1000);
        clear_stats();
        do_start(7, 5, t);
        wait_done(0, 1000);
        tick(2);
        check("b2b_min_x", 0, min_x[0], 140);
        check("b2b_max_x", 0, max_x[0], 159);
        check("b2b_min_y", 0, min_y[0], 100);
        check("b2b_max_y", 0, max_y[0], 119);
        check("b2b_last_addr", 0, last_wa[0], 399);
        check("b2b_last_data", 0, last_wd[0], 479);
        check("b2b_done_cyc", 0, done_cyc[0] - t, 404);

        // Randomized captures, spurious starts and resets.
        repeat (14) begin
            tick($urandom_range(0, 5));
            gx = $urandom_range(0, 9);
            gy = $urandom_range(0, 7);
            r = $urandom_range(0, 5);
            clear_stats();
            do_start(gx, gy, t);
            if (r == 0 && gx < 8 && gy < 6) begin
                tick($urandom_range(1, 300));
                resetn = 1'b0;
                tick(1);
                resetn = 1'b1;
                tick(2);
            end else begin
                if (r == 1 && gx < 8 && gy < 6) begin
                    tick($urandom_range(1, 300));
                    grid_x = 4'($urandom_range(0, 15));
                    grid_y = 4'($urandom_range(0, 15));
                    start = 1'b1;
                    tick(1);
                    start = 1'b0;
                end
                wait_done(0, 1000);
                tick(2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
